// File: rtl/hfswr_rx_pkg.sv
// Shared definitions for the receiver capture path: FSM state encoding,
// BRAM byte-offset width and frame counter width.
package hfswr_rx_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_BLOCKED = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    ARMED   = S_ARMED,
    CAPTURE = S_CAPTURE,
    COMMIT  = S_COMMIT,
    BLOCKED = S_BLOCKED
  } state_t;

  localparam int BYTE_OFFSET = 2;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/bank_status.sv
// Tracks which of the two banks hold unread frames and which one the PS
// should read next, keeping frames in oldest-first order.
module bank_status (
  input  logic       clk,
  input  logic       rst,
  input  logic       commit,
  input  logic       commit_bank,
  input  logic       rd_done,
  output logic [1:0] full,
  output logic       ready_bank,
  output logic       frame_ready,
  output logic       releasing
);

  logic [1:0] full_n;
  logic       ready_bank_n;
  logic       frame_ready_n;

  assign releasing = rd_done & frame_ready;

  // A release is applied before a same-cycle commit, so the commit sees the
  // post-release pending state and never overtakes an older frame.
  always_comb begin
    full_n        = full;
    ready_bank_n  = ready_bank;
    frame_ready_n = frame_ready;
    if (releasing) begin
      full_n[ready_bank] = 1'b0;
      if (full[~ready_bank]) ready_bank_n = ~ready_bank;
      else                   frame_ready_n = 1'b0;
    end
    if (commit) begin
      full_n[commit_bank] = 1'b1;
      if (!frame_ready_n) begin
        ready_bank_n  = commit_bank;
        frame_ready_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full        <= 2'b00;
      ready_bank  <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      full        <= full_n;
      ready_bank  <= ready_bank_n;
      frame_ready <= frame_ready_n;
    end
  end

endmodule

// File: rtl/bram_bank_sched.sv
// Ping-pong capture scheduler: writes receiver samples into the free half of
// the sample BRAM while the PS reads the other half.
module bram_bank_sched
  import hfswr_rx_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 1000,
  parameter int DATA_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   rd_done,
  output logic                   bram_we,
  output logic [31:0]            bram_addr,
  output logic [DATA_W-1:0]      bram_din,
  output logic                   frame_ready,
  output logic                   ready_bank,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic              wr_bank;
  logic [1:0]        full;
  logic              releasing;
  logic              commit;
  logic              other_free;

  assign commit = (state == COMMIT);
  // A bank being released in the commit cycle counts as free already.
  assign other_free = !full[~wr_bank] || (releasing && (ready_bank == ~wr_bank));

  bank_status u_bank_status (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .commit_bank (wr_bank),
    .rd_done     (rd_done),
    .full        (full),
    .ready_bank  (ready_bank),
    .frame_ready (frame_ready),
    .releasing   (releasing)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      wr_bank   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      bram_we <= 1'b0;
      if (commit) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (!en) begin
        state <= IDLE;
        index <= '0;
      end else begin
        case (state)
          IDLE:  state <= ARMED;
          ARMED: begin
            if (start) begin
              state <= CAPTURE;
              index <= '0;
            end
          end
          CAPTURE: begin
            if (s_valid) begin
              bram_we   <= 1'b1;
              bram_addr <= 32'({wr_bank, index, {BYTE_OFFSET{1'b0}}});
              bram_din  <= s_data;
              if (index == LAST_IDX) begin
                index <= '0;
                state <= COMMIT;
              end else begin
                index <= index + 1'b1;
              end
            end
          end
          COMMIT: state <= other_free ? ARMED : BLOCKED;
          BLOCKED: begin
            if (start)     overrun <= 1'b1;
            if (releasing) state   <= ARMED;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_bank_sched.sv
// Randomized and directed checks of bram_bank_sched against a queue-based
// model of the pending-frame list.
module tb_bram_bank_sched;

  localparam int ADDR_W    = 4;
  localparam int FRAME_LEN = 8;
  localparam int DATA_W    = 32;

  localparam int P_IDLE    = 0;
  localparam int P_ARMED   = 1;
  localparam int P_CAPTURE = 2;
  localparam int P_COMMIT  = 3;
  localparam int P_BLOCKED = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              rd_done = 1'b0;
  logic              bram_we;
  logic [31:0]       bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              frame_ready;
  logic              ready_bank;
  logic              overrun;
  logic [15:0]       frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: list of unread frames (bank numbers, oldest first) plus capture progress.
  bit q[$];
  int phase;
  int nsamp;
  bit m_wr;
  bit m_rb;
  bit m_ovr;
  int m_fcnt;
  bit e_we;
  int e_addr;
  int e_din;

  bram_bank_sched #(.ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .rd_done     (rd_done),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .frame_ready (frame_ready),
    .ready_bank  (ready_bank),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    q.delete();
    phase  = P_IDLE;
    nsamp  = 0;
    m_wr   = 0;
    m_rb   = 0;
    m_ovr  = 0;
    m_fcnt = 0;
    e_we   = 0;
    e_addr = 0;
    e_din  = 0;
  endtask

  task automatic modelStep();
    bit rel;
    bit com;
    rel  = rd_done && (q.size() > 0);
    com  = (phase == P_COMMIT);
    e_we = 0;
    if (rel) void'(q.pop_front());
    if (com) begin
      q.push_back(m_wr);
      m_wr   = !m_wr;
      m_fcnt = (m_fcnt + 1) % 65536;
    end
    if (q.size() > 0) m_rb = q[0];
    if (!en) begin
      phase = P_IDLE;
    end else begin
      case (phase)
        P_IDLE:  phase = P_ARMED;
        P_ARMED: if (start) begin phase = P_CAPTURE; nsamp = 0; end
        P_CAPTURE: begin
          if (s_valid) begin
            e_we   = 1;
            e_addr = int'(m_wr) * (2 ** ADDR_W) * 4 + nsamp * 4;
            e_din  = int'(s_data);
            nsamp++;
            if (nsamp == FRAME_LEN) phase = P_COMMIT;
          end
        end
        P_COMMIT: phase = (q.size() == 2) ? P_BLOCKED : P_ARMED;
        P_BLOCKED: begin
          if (start) m_ovr = 1;
          if (rel)   phase = P_ARMED;
        end
        default: phase = P_IDLE;
      endcase
    end
  endtask

  task automatic checkAll();
    checkOutput("bram_we", 32'(bram_we), 32'(e_we));
    if (e_we) begin
      checkOutput("bram_addr", bram_addr, 32'(e_addr));
      checkOutput("bram_din", bram_din, 32'(e_din));
    end
    checkOutput("frame_ready", 32'(frame_ready), 32'(q.size() > 0));
    checkOutput("ready_bank", 32'(ready_bank), 32'(m_rb));
    checkOutput("overrun", 32'(overrun), 32'(m_ovr));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
  endtask

  task automatic applyStimulus(input bit e, input bit st, input bit sv, input logic [DATA_W-1:0] d, input bit rd);
    en      = e;
    start   = st;
    s_valid = sv;
    s_data  = d;
    rd_done = rd;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic doFrame(input bit gapped, input bit mid_start);
    applyStimulus(1, 1, 0, '0, 0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      applyStimulus(1, mid_start && (i == 3), 1, $urandom, 0);
      if (gapped) applyStimulus(1, 0, 0, $urandom, 0);
    end
  endtask

  initial begin
    int en_off;
    bit e;
    bit sv;
    resetModel();
    #3;
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    // Basic frame into bank 0.
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 1, 0, '0, 0);
    for (int i = 0; i < FRAME_LEN; i++) applyStimulus(1, 0, 1, 32'h10 + 32'(i), 0);
    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("basic_ready", 32'(frame_ready), 32'd1);
    checkOutput("basic_bank", 32'(ready_bank), 32'd0);
    checkOutput("basic_cnt", 32'(frame_cnt), 32'd1);

    // Ping-pong second frame, then two reads.
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 1);
    checkOutput("pp_bank", 32'(ready_bank), 32'd1);
    checkOutput("pp_ready", 32'(frame_ready), 32'd1);
    applyStimulus(1, 0, 0, '0, 1);
    checkOutput("pp_drained", 32'(frame_ready), 32'd0);

    // Overrun with both banks full.
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 1, 1, 32'hdead, 0);
    checkOutput("ovr_flag", 32'(overrun), 32'd1);
    checkOutput("ovr_cnt", 32'(frame_cnt), 32'd4);
    applyStimulus(1, 0, 0, '0, 1);
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 0);

    // Gapped input with a start mid-capture; drain first.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1);
    doFrame(1, 1);
    applyStimulus(1, 0, 0, '0, 0);

    // Abort after three samples, then a fresh frame.
    applyStimulus(1, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, $urandom, 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 0);

    // Commit coinciding with rd_done.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1);
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    doFrame(0, 0);
    applyStimulus(1, 0, 0, '0, 1);
    checkOutput("simul_ready", 32'(frame_ready), 32'd1);
    checkOutput("simul_bank", 32'(ready_bank), 32'(!m_wr));

    // Reset mid-capture.
    applyStimulus(1, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, $urandom, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_we", 32'(bram_we), 32'd0);
    checkOutput("rst_addr", bram_addr, 32'd0);
    checkOutput("rst_din", bram_din, 32'd0);
    checkOutput("rst_ready", 32'(frame_ready), 32'd0);
    checkOutput("rst_bank", 32'(ready_bank), 32'd0);
    checkOutput("rst_ovr", 32'(overrun), 32'd0);
    checkOutput("rst_cnt", 32'(frame_cnt), 32'd0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    en_off = 0;
    for (int i = 0; i < 3000; i++) begin
      e = 1;
      if (en_off > 0) begin
        e = 0;
        en_off--;
      end else if (($urandom % 150) == 0 && (phase == P_ARMED || phase == P_CAPTURE)) begin
        e = 0;
        en_off = $urandom_range(0, 3);
      end
      sv = e && (($urandom % 3) != 0);
      applyStimulus(e, ($urandom % 12) == 0, sv, $urandom, ($urandom % 25) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_bank_sched.md
# bram_bank_sched

Ping-pong capture scheduler for the receiver sample BRAM. It splits one BRAM into two banks and starts a frame capture on each sweep `start` pulse. Incoming receiver samples are written into the free bank while the processor reads the other. It publishes which bank holds a completed frame and flags sweeps lost because both banks were occupied. The block sits between the receiver datapath and the BRAM port, under PS control through `en`/`rd_done`.

## Interface
- `ADDR_W`, 12: word-address width per bank; bank depth is 2**ADDR_W.
- `FRAME_LEN`, 1000: samples per frame; 1 ≤ FRAME_LEN ≤ 2**ADDR_W.
- `DATA_W`, 32: sample width.

- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  capture enable from PS (level).
- `start`  in  1  one-cycle sweep-start pulse from the TX sync.
- `s_valid`  in  1  sample strobe from the receiver datapath.
- `s_data`  in  DATA_W  sample value.
- `rd_done`  in  1  one-cycle pulse from PS: the ready bank has been consumed.
- `bram_we`  out  1  BRAM write enable.
- `bram_addr`  out  32  BRAM byte address = {bank, index, 2'b00}, zero-extended.
- `bram_din`  out  DATA_W  BRAM write data.
- `frame_ready`  out  1  a completed frame is waiting.
- `ready_bank`  out  1  bank holding the oldest unread frame.
- `overrun`  out  1  sticky; set when a sweep was dropped.
- `frame_cnt`  out  16  completed frames, wraps modulo 2^16.

## Operation
- States:
  - `IDLE`: `en`=0.
  - `ARMED`: waiting for `start`.
  - `CAPTURE`: writing samples.
  - `COMMIT`: one cycle.
  - `BLOCKED`: both banks full.
- Transitions:
  - IDLE→ARMED when `en`=1.
  - ARMED→CAPTURE on `start`; `index` cleared to 0.
  - CAPTURE→COMMIT when the FRAME_LEN-th sample is accepted.
  - COMMIT→ARMED if bank `wr_bank^1` is free, else →BLOCKED.
  - BLOCKED→ARMED when `rd_done` frees a bank.
  - Any state→IDLE when `en`=0. In CAPTURE this aborts: the partial frame is discarded, the bank is not marked full, and `index` resets.
- Sample acceptance: `s_valid` is accepted only in CAPTURE. Samples outside CAPTURE are ignored.
- `start` handling:
  - Ignored in CAPTURE and COMMIT (no re-trigger).
  - In BLOCKED, `start` sets `overrun`; `overrun` clears only on `rst`.
- COMMIT actions:
  - `full[wr_bank]` ← 1.
  - `wr_bank` toggles.
  - `frame_cnt` increments.
  - If no frame was pending, `ready_bank` ← committing bank and `frame_ready` ← 1.
- `rd_done` with `frame_ready`=1:
  - Clears `full[ready_bank]`.
  - If the other bank is full, `ready_bank` toggles and `frame_ready` stays 1; otherwise `frame_ready` ← 0.
- `rd_done` with `frame_ready`=0 is ignored.
- Simultaneous COMMIT and `rd_done`: `rd_done` is applied first, to the old `ready_bank`, then the commit is applied. No frame is lost and ordering is preserved (oldest first).
- Index arithmetic: `index` is ADDR_W bits and counts 0..FRAME_LEN-1; it never wraps inside a frame.

## Timing
- Reset values:
  - `bram_we`=0, `bram_addr`=0, `bram_din`=0.
  - `frame_ready`=0, `ready_bank`=0, `overrun`=0, `frame_cnt`=0.
  - `wr_bank`=0, `full`=2'b00, state IDLE.
- All outputs are registered.
- A sample accepted in cycle N gives `bram_we`=1, `bram_addr`, `bram_din` in cycle N+1, with no stalls. Back-to-back `s_valid` gives back-to-back writes.
- Start latency: `start` in cycle N allows acceptance of `s_valid` from cycle N+1.
- Commit latency: last sample accepted in N → last write in N+1, COMMIT in N+1, `frame_ready`/`frame_cnt` updated in N+2.
- `rd_done` in N → `frame_ready`/`ready_bank` updated in N+1.
- Abort on `en` fall: state IDLE in the next cycle. A write already registered still completes in that cycle.

## Structure
- Shared package `hfswr_rx_pkg` holds:
  - state encoding localparams (IDLE..BLOCKED);
  - the byte-offset constant (2);
  - the `frame_cnt` width.
- One sub-module, `bank_status`, owns `full[1:0]`, `ready_bank`, `frame_ready` and the commit/release ordering rule.
- The top level keeps the FSM, index counter and BRAM output registers.

## Test plan
All scenarios use ADDR_W=4, FRAME_LEN=8.
- **Basic frame:** `en`=1, `start`, 8 consecutive samples 0x10..0x17 → writes to bytes 0x00..0x1C with those data; `frame_ready`=1, `ready_bank`=0, `frame_cnt`=1.
- **Ping-pong:** second sweep without `rd_done` → writes to bytes 0x40..0x5C. Then `rd_done` → `ready_bank`=1, `frame_ready` stays 1. Second `rd_done` → `frame_ready`=0.
- **Overrun:** both banks full, then `start` → `overrun`=1, no `bram_we`, `frame_cnt` unchanged. After `rd_done`, the next `start` captures into bank 0.
- **Gapped input:** `s_valid` on alternate cycles → 8 writes, address increments only on accepted samples; `start` mid-capture is ignored.
- **Abort:** `en`=0 after 3 samples → IDLE, `frame_ready` unchanged. The next frame restarts at index 0 in the same bank.
- **Simultaneous events:** `rd_done` in the same cycle as COMMIT → old bank released, new bank becomes `ready_bank`, `frame_ready` stays 1. Also assert `rst` mid-capture → all outputs return to reset values immediately.
